note_recorder: RTL and testbench



---
 rtl/note_recorder_pkg.sv | 20 ++
 rtl/note_buffer.sv | 25 ++
 rtl/note_recorder.sv | 183 ++++++++++++++++++
 tb/tb_note_recorder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_recorder_pkg.sv
// Shared definitions for the note recorder: note codes and FSM state encoding.
package note_recorder_pkg;

  localparam logic [3:0] NOTE_NONE = 4'd0;
  localparam logic [3:0] NOTE_C4   = 4'd1;
  localparam logic [3:0] NOTE_D4   = 4'd2;
  localparam logic [3:0] NOTE_E4   = 4'd3;
  localparam logic [3:0] NOTE_F4   = 4'd4;
  localparam logic [3:0] NOTE_G4   = 4'd5;
  localparam logic [3:0] NOTE_A4   = 4'd6;
  localparam logic [3:0] NOTE_B4   = 4'd7;
  localparam logic [3:0] NOTE_C5   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RECORD = 2'd1,
    ST_PLAY   = 2'd2
  } rec_state_t;

endpackage

// File: rtl/note_buffer.sv
// Segment store: single-port RAM with synchronous read, one {note, duration} per entry.
module note_buffer #(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned WIDTH = 10
) (
  input  logic                     CLK,
  input  logic                     we,
  input  logic                     re,
  input  logic [$clog2(DEPTH)-1:0] addr,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Write has the port when both are requested; read data is registered.
  always_ff @(posedge CLK) begin
    if (we) begin
      mem[addr] <= wdata;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/note_recorder.sv
// Record/replay stage in front of the tone selector: captures (note, quarter-beat
// duration) segments while recording and replays them at the same beat rate.
module note_recorder
  import note_recorder_pkg::*;
#(
  parameter int unsigned DEPTH = 32,
  parameter int unsigned DUR_W = 6
) (
  input  logic                     CLK,
  input  logic                     RESET_N,
  input  logic                     QUARTER_BEAT,
  input  logic                     REC,
  input  logic                     PLAY,
  input  logic                     STOP,
  input  logic [3:0]               in_note,
  output logic [3:0]               out_note,
  output logic [1:0]               state,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned EW = 4 + DUR_W;
  localparam logic [DUR_W-1:0] DUR_MAX = '1;
  localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

  rec_state_t       st;
  logic [3:0]       cur;
  logic [DUR_W-1:0] dur;
  logic [DUR_W-1:0] rem;
  logic [CW-1:0]    rd;
  logic             fetch;
  logic             load;
  logic [1:0]       pend;

  logic [DUR_W-1:0] dur_tick;
  logic             wr_en;
  logic [EW-1:0]    wr_data;
  logic [EW-1:0]    rd_data;
  logic [AW-1:0]    ram_addr;
  logic             ram_re;
  logic [CW-1:0]    count_inc;
  logic [CW-1:0]    rd_inc;
  logic [3:0]       ld_note;
  logic [DUR_W-1:0] ld_dur;
  logic [DUR_W:0]   eff;
  logic [DUR_W:0]   eff_diff;
  logic             ld_over;
  logic [1:0]       pend_inc;
  logic             seg_done;
  logic             last_seg;

  assign state = st;
  assign full  = (count == DEPTH_C);

  // Segment-close and playback bookkeeping derived from the current cycle.
  always_comb begin
    dur_tick  = (QUARTER_BEAT && dur != DUR_MAX) ? dur + DUR_W'(1) : dur;
    wr_en     = (st == ST_RECORD) && (STOP || in_note != cur) && (dur_tick != '0);
    wr_data   = {cur, dur_tick};
    ram_re    = (st == ST_PLAY) && fetch;
    ram_addr  = (st == ST_RECORD) ? count[AW-1:0] : rd[AW-1:0];
    count_inc = count + CW'(1);
    rd_inc    = rd + CW'(1);
    ld_note   = rd_data[EW-1:DUR_W];
    ld_dur    = rd_data[DUR_W-1:0];
    // Ticks seen while the next entry was being fetched are charged to it on load.
    eff       = (DUR_W+1)'(pend) + (DUR_W+1)'(QUARTER_BEAT);
    eff_diff  = eff - {1'b0, ld_dur};
    ld_over   = (eff >= {1'b0, ld_dur});
    pend_inc  = (QUARTER_BEAT && pend != 2'b11) ? pend + 2'd1 : pend;
    seg_done  = (load && ld_over) ||
                (!fetch && !load && QUARTER_BEAT && rem == DUR_W'(1));
    last_seg  = (rd_inc == count);
  end

  note_buffer #(
    .DEPTH (DEPTH),
    .WIDTH (EW)
  ) u_buffer (
    .CLK   (CLK),
    .we    (wr_en),
    .re    (ram_re),
    .addr  (ram_addr),
    .wdata (wr_data),
    .rdata (rd_data)
  );

  // Control FSM with registered note output and segment counters.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      st       <= ST_IDLE;
      out_note <= NOTE_NONE;
      count    <= '0;
      cur      <= NOTE_NONE;
      dur      <= '0;
      rem      <= '0;
      rd       <= '0;
      fetch    <= 1'b0;
      load     <= 1'b0;
      pend     <= '0;
    end else begin
      case (st)
        ST_IDLE: begin
          out_note <= in_note;
          if (STOP) begin
            // no effect in idle
          end else if (REC) begin
            count <= '0;
            cur   <= in_note;
            dur   <= '0;
            st    <= ST_RECORD;
          end else if (PLAY && count != '0) begin
            rd    <= '0;
            fetch <= 1'b1;
            load  <= 1'b0;
            pend  <= '0;
            st    <= ST_PLAY;
          end
        end

        ST_RECORD: begin
          out_note <= in_note;
          if (wr_en) begin
            count <= count_inc;
          end
          if (STOP) begin
            dur <= '0;
            st  <= ST_IDLE;
          end else if (in_note != cur) begin
            cur <= in_note;
            dur <= '0;
            if (wr_en && count_inc == DEPTH_C) begin
              st <= ST_IDLE;
            end
          end else begin
            dur <= dur_tick;
          end
        end

        ST_PLAY: begin
          if (STOP) begin
            out_note <= NOTE_NONE;
            fetch    <= 1'b0;
            load     <= 1'b0;
            pend     <= '0;
            st       <= ST_IDLE;
          end else begin
            if (fetch) begin
              fetch <= 1'b0;
              load  <= 1'b1;
              pend  <= pend_inc;
            end else if (load) begin
              load     <= 1'b0;
              out_note <= ld_note;
              rem      <= ld_over ? '0 : ld_dur - eff[DUR_W-1:0];
              pend     <= ld_over ? eff_diff[1:0] : 2'd0;
            end else if (QUARTER_BEAT) begin
              rem <= rem - DUR_W'(1);
            end
            if (seg_done) begin
              if (last_seg) begin
                out_note <= NOTE_NONE;
                fetch    <= 1'b0;
                pend     <= '0;
                st       <= ST_IDLE;
              end else begin
                rd    <= rd_inc;
                fetch <= 1'b1;
              end
            end
          end
        end

        default: begin
          st <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_note_recorder.sv
// Directed bench for note_recorder: recorded segments go into a scoreboard
// queue and are compared against the replayed note stream.
module tb_note_recorder;

  localparam int unsigned DEPTH = 32;
  localparam int unsigned DUR_W = 6;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic          CLK = 1'b0;
  logic          RESET_N = 1'b0;
  logic          QUARTER_BEAT = 1'b0;
  logic          REC = 1'b0;
  logic          PLAY = 1'b0;
  logic          STOP = 1'b0;
  logic [3:0]    in_note = 4'd0;
  logic [3:0]    out_note;
  logic [1:0]    state;
  logic [CW-1:0] count;
  logic          full;

  typedef struct {
    logic [3:0] note;
    int         dur;
  } seg_t;

  seg_t sb[$];
  seg_t saved[$];
  int   n_checks = 0;
  int   n_fails  = 0;

  note_recorder #(
    .DEPTH (DEPTH),
    .DUR_W (DUR_W)
  ) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .QUARTER_BEAT (QUARTER_BEAT),
    .REC          (REC),
    .PLAY         (PLAY),
    .STOP         (STOP),
    .in_note      (in_note),
    .out_note     (out_note),
    .state        (state),
    .count        (count),
    .full         (full)
  );

  always #5 CLK = ~CLK;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // One idle cycle followed by a quarter-beat strobe cycle.
  task automatic qtick();
    step();
    QUARTER_BEAT = 1'b1;
    step();
    QUARTER_BEAT = 1'b0;
  endtask

  // Issue PLAY and compare the replayed stream with the scoreboard contents.
  task automatic play_check();
    seg_t s;
    PLAY = 1'b1;
    step();
    PLAY = 1'b0;
    check("play_state", 16'(state), 16'd2);
    step();
    step();
    while (sb.size() > 0) begin
      s = sb.pop_front();
      check("play_note", 16'(out_note), 16'(s.note));
      for (int k = 0; k < s.dur; k++) begin
        step();
        check("play_hold", 16'(out_note), 16'(s.note));
        QUARTER_BEAT = 1'b1;
        step();
        QUARTER_BEAT = 1'b0;
      end
      if (sb.size() > 0) begin
        step();
        check("play_gap_hold", 16'(out_note), 16'(s.note));
        step();
      end
    end
    check("play_end_state", 16'(state), 16'd0);
    check("play_end_note", 16'(out_note), 16'd0);
  endtask

  initial begin
    int        exp_count;
    int        exp_state;
    logic [3:0] nt;

    // Reset values
    repeat (2) step();
    check("reset_state", 16'(state), 16'd0);
    check("reset_note", 16'(out_note), 16'd0);
    check("reset_count", 16'(count), 16'd0);
    check("reset_full", 16'(full), 16'd0);
    RESET_N = 1'b1;
    step();

    // Idle passthrough
    in_note = 4'd5;
    step();
    check("idle_pass", 16'(out_note), 16'd5);

    // Record C4 x3, E x2, G for zero ticks, NONE x1, then STOP
    in_note = 4'd1;
    REC = 1'b1;
    step();
    REC = 1'b0;
    check("rec_state", 16'(state), 16'd1);
    check("rec_count_clear", 16'(count), 16'd0);
    repeat (3) qtick();
    in_note = 4'd3;
    step();
    sb.push_back('{note: 4'd1, dur: 3});
    check("rec_count1", 16'(count), 16'd1);
    repeat (2) qtick();
    in_note = 4'd5;
    step();
    sb.push_back('{note: 4'd3, dur: 2});
    check("rec_count2", 16'(count), 16'd2);
    check("rec_pass", 16'(out_note), 16'd5);
    in_note = 4'd0;
    step();
    check("rec_dur0_skip", 16'(count), 16'd2);
    qtick();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    sb.push_back('{note: 4'd0, dur: 1});
    check("stop_count", 16'(count), 16'd3);
    check("stop_state", 16'(state), 16'd0);
    check("stop_full", 16'(full), 16'd0);
    saved = sb;

    // REC together with STOP in idle does nothing
    REC = 1'b1;
    STOP = 1'b1;
    step();
    REC = 1'b0;
    STOP = 1'b0;
    check("recstop_state", 16'(state), 16'd0);
    check("recstop_count", 16'(count), 16'd3);

    // Full playback of the three segments
    play_check();
    check("play_count_kept", 16'(count), 16'd3);

    // STOP after one beat of playback
    PLAY = 1'b1;
    step();
    PLAY = 1'b0;
    step();
    step();
    check("abort_first_note", 16'(out_note), 16'd1);
    qtick();
    STOP = 1'b1;
    step();
    STOP = 1'b0;
    check("abort_state", 16'(state), 16'd0);
    check("abort_note", 16'(out_note), 16'd0);
    check("abort_count", 16'(count), 16'd3);

    // A tick inside the fetch gap is charged to the next segment
    PLAY = 1'b1;
    step();
    PLAY = 1'b0;
    step();
    step();
    repeat (3) qtick();
    QUARTER_BEAT = 1'b1;
    step();
    QUARTER_BEAT = 1'b0;
    step();
    check("gap_tick_note", 16'(out_note), 16'd3);
    check("gap_tick_state", 16'(state), 16'd2);
    qtick();
    step();
    step();
    check("gap_tick_next", 16'(out_note), 16'd0);
    check("gap_tick_still_play", 16'(state), 16'd2);
    qtick();
    check("gap_tick_end", 16'(state), 16'd0);

    // Asynchronous reset in the middle of playback
    PLAY = 1'b1;
    step();
    PLAY = 1'b0;
    step();
    step();
    check("pre_reset_note", 16'(out_note), 16'd1);
    RESET_N = 1'b0;
    #1;
    check("midplay_rst_note", 16'(out_note), 16'd0);
    check("midplay_rst_state", 16'(state), 16'd0);
    check("midplay_rst_count", 16'(count), 16'd0);
    #1;
    RESET_N = 1'b1;
    step();

    // PLAY with an empty buffer stays idle
    PLAY = 1'b1;
    step();
    PLAY = 1'b0;
    check("play_empty", 16'(state), 16'd0);
    step();
    check("play_empty2", 16'(state), 16'd0);

    // Fill the buffer with DEPTH+2 one-beat segments
    sb.delete();
    exp_count = 0;
    exp_state = 1;
    in_note = 4'd1;
    REC = 1'b1;
    step();
    REC = 1'b0;
    for (int i = 0; i < int'(DEPTH) + 2; i++) begin
      nt = in_note;
      qtick();
      in_note = 4'((i + 1) % 8 + 1);
      step();
      if (exp_state == 1) begin
        sb.push_back('{note: nt, dur: 1});
        exp_count++;
        if (exp_count == int'(DEPTH)) exp_state = 0;
      end
      check("fill_count", 16'(count), 16'(exp_count));
      check("fill_state", 16'(state), 16'(exp_state));
    end
    check("fill_full", 16'(full), 16'd1);
    check("fill_final_count", 16'(count), 16'(DEPTH));
    play_check();
    check("fill_count_kept", 16'(count), 16'(DEPTH));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
